// File: rtl/noc_wormhole_switch_allocator_pkg.sv
// Shared types and constants for the 7-port 3D mesh wormhole allocator.
// Watchdog sizing lives here; it only matters when SA_WATCHDOG_EN is set.
package noc_pkg;

  localparam int NPORT    = 7;
  localparam int PW       = 3;
  localparam int FLIT_W   = 40;
  localparam int WD_LIMIT = 64;
  localparam int WD_W     = $clog2(WD_LIMIT);

  typedef enum logic [PW-1:0] {
    P_E    = 3'd0,
    P_W    = 3'd1,
    P_N    = 3'd2,
    P_S    = 3'd3,
    P_PE   = 3'd4,
    P_UP   = 3'd5,
    P_DOWN = 3'd6
  } port_e;

  localparam logic [1:0] FT_HDR  = 2'b11;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b01;
  localparam logic [1:0] FT_IDLE = 2'b00;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } sa_state_e;

  function automatic logic [1:0] ftype(
    input logic [2*NPORT-1:0] t,
    input int                 i
  );
    return t[2*i +: 2];
  endfunction

  function automatic logic [PW-1:0] froute(
    input logic [PW*NPORT-1:0] r,
    input int                  i
  );
    return r[PW*i +: PW];
  endfunction

  function automatic logic [PW-1:0] nxt_port(
    input logic [PW-1:0] p
  );
    return (p == PW'(NPORT-1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/noc_wormhole_switch_allocator_if.sv
// Allocator-side bundle: FIFO heads, downstream ready, pops, crossbar ctl.
// master = FIFO/route/crossbar side, slave = the allocator.
interface noc_wormhole_switch_allocator_if;
  import noc_pkg::*;

  logic [NPORT-1:0]    in_valid;
  logic [2*NPORT-1:0]  in_type;
  logic [PW*NPORT-1:0] in_route;
  logic [NPORT-1:0]    out_ready;
  logic [NPORT-1:0]    in_pop;
  logic [NPORT-1:0]    out_valid;
  logic [PW*NPORT-1:0] out_sel;
  logic [NPORT-1:0]    out_busy;
  logic                err_proto;

  modport master (
    output in_valid, in_type, in_route, out_ready,
    input  in_pop, out_valid, out_sel, out_busy, err_proto
  );

  modport slave (
    input  in_valid, in_type, in_route, out_ready,
    output in_pop, out_valid, out_sel, out_busy, err_proto
  );

endinterface

// File: rtl/noc_wormhole_switch_allocator_rr_arbiter.sv
// Combinational 7-way round-robin pick.
// Search starts at ptr and wraps from the last port back to 0.
module noc_rr_arbiter
  import noc_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             grant_valid,
  output logic [PW-1:0]    grant_idx
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_c;

  // first requester at or after ptr, modulo NPORT
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_sum       = '0;
    w_c         = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NPORT))
        w_sum = w_sum - (PW+1)'(NPORT);
      w_c = w_sum[PW-1:0];
      if (!grant_valid && req[w_c]) begin
        grant_valid = 1'b1;
        grant_idx   = w_c;
      end
    end
  end

endmodule

// File: rtl/noc_wormhole_switch_allocator.sv
// Wormhole switch allocator: per-output RR grant, lock until tail.
// Optional stall watchdog: define SA_WATCHDOG_EN.
module noc_wormhole_switch_allocator (
  input logic clk,
  input logic rst,
  noc_wormhole_switch_allocator_if.slave bus
);
  import noc_pkg::*;

  sa_state_e        r_state [NPORT];
  sa_state_e        w_state [NPORT];
  logic [PW-1:0]    r_owner [NPORT];
  logic [PW-1:0]    w_owner [NPORT];
  logic [PW-1:0]    r_ptr   [NPORT];
  logic [PW-1:0]    w_ptr   [NPORT];
  logic [PW-1:0]    r_dest  [NPORT];
  logic [PW-1:0]    w_dest  [NPORT];
  logic [NPORT-1:0] r_hdr, w_hdr;
  logic [NPORT-1:0] r_lock, w_lock;
  logic             r_err, w_err;

  logic [NPORT-1:0] w_req [NPORT];
  logic [NPORT-1:0] w_gv;
  logic [PW-1:0]    w_gi  [NPORT];
  logic [NPORT-1:0] w_fire;
  logic [1:0]       w_oft [NPORT];

`ifdef SA_WATCHDOG_EN
  logic [WD_W-1:0]  r_wd [NPORT];
  logic [WD_W-1:0]  w_wd [NPORT];
`endif

  // header requests from unlocked inputs to idle outputs
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        w_req[o][i] = (r_state[o] == S_IDLE)
                    & bus.in_valid[i]
                    & ~r_lock[i]
                    & (ftype(bus.in_type, i) == FT_HDR)
                    & (froute(bus.in_route, i) == PW'(o));
      end
    end
  end

  // owner flit transfer and its type, per output
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      w_oft[o]  = ftype(bus.in_type, int'(r_owner[o]));
      w_fire[o] = (r_state[o] == S_LOCKED)
                & bus.in_valid[r_owner[o]]
                & bus.out_ready[o];
    end
  end

  for (genvar g = 0; g < NPORT; g++) begin : g_out
    noc_rr_arbiter u_arb (
      .req         (w_req[g]),
      .ptr         (r_ptr[g]),
      .grant_valid (w_gv[g]),
      .grant_idx   (w_gi[g])
    );
    assign bus.out_sel[g*PW +: PW] = r_owner[g];
    assign bus.out_busy[g]         = (r_state[g] == S_LOCKED);
    assign bus.in_pop[g]           = r_lock[g]
                                   & bus.in_valid[g]
                                   & bus.out_ready[r_dest[g]];
  end

  assign bus.out_valid = w_fire;
  assign bus.err_proto = r_err;

  // next-state: grant, transfer, tail release, protocol errors
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_ptr   = r_ptr;
    w_dest  = r_dest;
    w_hdr   = r_hdr;
    w_lock  = r_lock;
    w_err   = 1'b0;
`ifdef SA_WATCHDOG_EN
    w_wd    = r_wd;
`endif
    for (int i = 0; i < NPORT; i++) begin
      if (bus.in_valid[i] && !r_lock[i] &&
          (ftype(bus.in_type, i) inside {FT_BODY, FT_TAIL}))
        w_err = 1'b1;
    end
    for (int o = 0; o < NPORT; o++) begin
      unique case (r_state[o])
        S_IDLE: begin
          if (w_gv[o]) begin
            w_state[o]       = S_LOCKED;
            w_owner[o]       = w_gi[o];
            w_hdr[o]         = 1'b0;
            w_lock[w_gi[o]]  = 1'b1;
            w_dest[w_gi[o]]  = PW'(o);
          end
`ifdef SA_WATCHDOG_EN
          w_wd[o] = '0;
`endif
        end
        S_LOCKED: begin
          if (w_fire[o]) begin
            w_hdr[o] = 1'b1;
            if (w_oft[o] == FT_HDR && r_hdr[o])
              w_err = 1'b1;
            if (w_oft[o] == FT_TAIL) begin
              w_state[o]         = S_IDLE;
              w_ptr[o]           = nxt_port(r_owner[o]);
              w_lock[r_owner[o]] = 1'b0;
            end
          end
`ifdef SA_WATCHDOG_EN
          if (w_fire[o]) begin
            w_wd[o] = '0;
          end else if (!bus.in_valid[r_owner[o]]) begin
            if (r_wd[o] == WD_W'(WD_LIMIT-1)) begin
              w_state[o]         = S_IDLE;
              w_ptr[o]           = nxt_port(r_owner[o]);
              w_lock[r_owner[o]] = 1'b0;
              w_err              = 1'b1;
              w_wd[o]            = '0;
            end else begin
              w_wd[o] = r_wd[o] + 1'b1;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // state, owner, pointer and lock table registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NPORT; o++) begin
        r_state[o] <= S_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= PW'(P_E);
        r_dest[o]  <= '0;
`ifdef SA_WATCHDOG_EN
        r_wd[o]    <= '0;
`endif
      end
      r_hdr  <= '0;
      r_lock <= '0;
      r_err  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_ptr   <= w_ptr;
      r_dest  <= w_dest;
`ifdef SA_WATCHDOG_EN
      r_wd    <= w_wd;
`endif
      r_hdr   <= w_hdr;
      r_lock  <= w_lock;
      r_err   <= w_err;
    end
  end

endmodule
